bar_sprite_core: RTL
====================

Name: bar_sprite_core

Overview:
- Downstream consumer of the bar sprite RAM: instantiates it, turns the VGA pixel scan (x, y) into RAM read addresses and emits the bar's pixel colour plus a valid/transparent flag to the layer mux.
- Owns the bar's position and its per-frame fall motion.
- Programmed by the CPU through a small register bus.
- Reports when a bar falls off the bottom of the screen, so game logic can score a miss.

Parameters:
- CD, 10, colour depth in bits; matches the sprite RAM data width.
- BAR_W_BITS, 5, log2 of bar width in pixels (32).
- BAR_H_BITS, 5, log2 of bar height in pixels (32). The RAM address width is BAR_W_BITS+BAR_H_BITS = 10.
- KEY_COLOR, 0, chroma-key colour; pixels of this value are transparent.
- V_LIMIT, 480, first row below the visible screen.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous, active-low reset.
- x  in  11  current pixel column from the VGA sync counter.
- y  in  11  current pixel row from the VGA sync counter.
- frame_start  in  1  one-cycle pulse once per frame, at the start of vblank.
- wr_en  in  1  register write strobe.
- wr_addr  in  2  register select: 0=CTRL, 1=X0, 2=Y0.
- wr_data  in  32  register write data.
- spr_we  in  1  sprite RAM write enable.
- spr_addr  in  10  sprite RAM write address.
- spr_din  in  CD  sprite RAM write data.
- bar_rgb  out  CD  bar pixel colour; 2-cycle latency from x/y.
- bar_valid  out  1  pixel is inside the bar, non-transparent and drawable.
- bar_ypos  out  12  current signed top row of the bar.
- bar_missed  out  1  one-cycle pulse when the bar crosses V_LIMIT.

Behaviour:
- Registers:
  - CTRL[0] = enable (draw).
  - CTRL[1] = run (fall).
  - CTRL[5:2] = speed (0–15 rows per frame).
  - X0 = wr_data[10:0], the bar's left column.
  - Y0 = wr_data[11:0], signed; loads the position register. Negative values let a bar enter from above the screen.
- Reset (asynchronous, rst_n low):
  - CTRL = 0, x0 = 0, y_pos = 0, state = IDLE.
  - bar_rgb = 0, bar_valid = 0, bar_missed = 0.
  - All pipeline registers cleared.
- FSM states:
  - IDLE: y_pos holds. Go to FALL when CTRL.run = 1.
  - FALL: on each frame_start, y_pos <= y_pos + speed. If the updated y_pos >= V_LIMIT, pulse bar_missed for 1 cycle, go to EXPIRED and clear CTRL.run. If CTRL.run is cleared by software, go to IDLE.
  - EXPIRED: the bar is not drawn. A write to Y0 returns the FSM to IDLE.
- Any Y0 write in any state loads y_pos and puts the state to IDLE; CTRL.run is left unchanged, so the FSM re-enters FALL on the next cycle if run = 1.
- A Y0 write in the same cycle as frame_start takes priority; no increment is applied that frame.
- speed = 0 in FALL keeps the bar stationary; no miss is generated.
- Arithmetic: y_pos is 12-bit signed. The add is performed at 13 bits before the compare, so there is no wrap-around. x0 and y_pos may change mid-frame; the new values take effect on the next pixel.
- Pixel pipeline:
  - Stage 0 (combinational into the RAM address): xrel = x − x0 and yrel = y − y_pos, both computed signed at 13 bits. in_region = 0 ≤ xrel < 2^BAR_W_BITS and 0 ≤ yrel < 2^BAR_H_BITS. addr_r = {yrel[BAR_H_BITS-1:0], xrel[BAR_W_BITS-1:0]}.
  - Stage 1: the RAM returns data one cycle later; in_region and drawable (enable && state != EXPIRED) are registered alongside it.
  - Stage 2: bar_rgb <= ram_dout, and bar_valid <= in_region_d && drawable_d && ram_dout != KEY_COLOR.
  - Total latency: 2 clocks from x/y to bar_rgb/bar_valid. The layer mux delays its other inputs to match.
- Sprite RAM writes (spr_we) are independent of the FSM. A write to the address being read in the same cycle returns old data (read-before-write).
- Deassertion of rst_n is assumed to be synchronised externally.

Decomposition:
- Package bar_pkg holds:
  - register address constants REG_CTRL, REG_X0, REG_Y0;
  - CTRL bit-field constants;
  - typedef enum logic [1:0] {IDLE, FALL, EXPIRED} bar_state_t;
  - V_LIMIT, and the pixel coordinate width (11).
- Exactly one sub-module: the existing bar sprite RAM (bar_ram), instantiated with ADDR_WIDTH=10 and DATA_WIDTH=CD. Everything else stays flat.

Test Plan:
- Latency/addressing: preload RAM[addr] = addr; X0=100, Y0=50, enable=1; drive (x=103, y=52) → 2 cycles later bar_rgb = 0x043 (addr 67), bar_valid = 1. Drive (x=99, y=52) → bar_valid = 0.
- Chroma key: RAM[0] = KEY_COLOR (0); drive (x=100, y=50) → bar_valid = 0. Drive (x=101, y=50) → bar_valid = 1, bar_rgb = 1.
- Fall and miss: Y0=440, speed=15, run=1; 3 frame_start pulses → y_pos = 455, 470, 485. bar_missed pulses once, coincident with the 485 update. State is EXPIRED, CTRL.run reads 0, and no pixel is valid.
- Negative entry and write priority: Y0 = −20 (0xFEC), speed=4, run=1. Y0 write of 0 coincident with frame_start → y_pos = 0, not 4. Before that write, at y_pos = −16, pixel (x0, 10) reads RAM address {5'd26, 5'd0}.
- Reset mid-operation: assert rst_n low during FALL, asynchronously between clock edges → all outputs and y_pos read 0 immediately, state IDLE. After release, no bar_missed pulse and no motion until CTRL is rewritten.
- Restart from EXPIRED: with the FSM in EXPIRED, write Y0=0 then CTRL run=1 → the bar is drawn again, and it advances by speed on the next frame_start.

Source files
------------

// File: rtl/bar_pkg.sv
// Shared constants and types for the falling bar sprite.
package bar_pkg;

  localparam int unsigned COORD_W = 11;
  localparam int unsigned YPOS_W  = 12;
  localparam int unsigned CALC_W  = 13;
  localparam int unsigned V_LIMIT = 480;

  localparam logic [1:0] REG_CTRL = 2'd0;
  localparam logic [1:0] REG_X0   = 2'd1;
  localparam logic [1:0] REG_Y0   = 2'd2;

  localparam int unsigned CTRL_W         = 6;
  localparam int unsigned CTRL_ENABLE    = 0;
  localparam int unsigned CTRL_RUN       = 1;
  localparam int unsigned CTRL_SPEED_LSB = 2;
  localparam int unsigned CTRL_SPEED_W   = 4;

  typedef enum logic [1:0] {IDLE, FALL, EXPIRED} bar_state_t;

endpackage

// File: rtl/bar_ram.sv
// Simple dual-port sprite RAM: one write port, one registered read port.
module bar_ram #(
  parameter int unsigned ADDR_WIDTH = 10,
  parameter int unsigned DATA_WIDTH = 10
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] din,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [DATA_WIDTH-1:0] dout
);

  localparam int unsigned DEPTH = 1 << ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[wr_addr] <= din;
  end

  // Same-address read sees the pre-write contents.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) dout <= '0;
    else        dout <= mem[rd_addr];
  end

endmodule

// File: rtl/bar_sprite_core.sv
// Falling bar sprite: CPU-programmed position/motion, pixel lookup into the
// sprite RAM and a miss pulse when the bar leaves the bottom of the screen.
module bar_sprite_core
  import bar_pkg::*;
#(
  parameter int unsigned    CD         = 10,
  parameter int unsigned    BAR_W_BITS = 5,
  parameter int unsigned    BAR_H_BITS = 5,
  parameter logic [CD-1:0]  KEY_COLOR  = '0
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [10:0]        x,
  input  logic [10:0]        y,
  input  logic               frame_start,
  input  logic               wr_en,
  input  logic [1:0]         wr_addr,
  input  logic [31:0]        wr_data,
  input  logic               spr_we,
  input  logic [9:0]         spr_addr,
  input  logic [CD-1:0]      spr_din,
  output logic [CD-1:0]      bar_rgb,
  output logic               bar_valid,
  output logic [11:0]        bar_ypos,
  output logic               bar_missed
);

  localparam int unsigned AW = BAR_W_BITS + BAR_H_BITS;
  localparam logic signed [CALC_W-1:0] V_LIM_S = $signed(CALC_W'(V_LIMIT));

  logic [CTRL_W-1:0]         ctrl;
  logic [COORD_W-1:0]        x0;
  logic signed [YPOS_W-1:0]  y_pos;
  bar_state_t                state;

  logic                      enable_c;
  logic                      run_c;
  logic [CTRL_SPEED_W-1:0]   speed_c;
  logic signed [CALC_W-1:0]  y_next_c;
  logic                      hit_limit_c;
  logic                      y0_wr_c;

  assign enable_c    = ctrl[CTRL_ENABLE];
  assign run_c       = ctrl[CTRL_RUN];
  assign speed_c     = ctrl[CTRL_SPEED_LSB +: CTRL_SPEED_W];
  assign y_next_c    = {y_pos[YPOS_W-1], y_pos} + CALC_W'(speed_c);
  assign hit_limit_c = (y_next_c >= V_LIM_S) && (speed_c != '0);
  assign y0_wr_c     = wr_en && (wr_addr == REG_Y0);
  assign bar_ypos    = y_pos;

  logic unused_wr_bits;
  assign unused_wr_bits = ^wr_data[31:YPOS_W];

  // Register file and fall FSM; a Y0 write overrides any frame update.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ctrl       <= '0;
      x0         <= '0;
      y_pos      <= '0;
      state      <= IDLE;
      bar_missed <= 1'b0;
    end else begin
      bar_missed <= 1'b0;
      if (wr_en && (wr_addr == REG_CTRL)) ctrl <= wr_data[CTRL_W-1:0];
      if (wr_en && (wr_addr == REG_X0))   x0   <= wr_data[COORD_W-1:0];
      if (y0_wr_c) begin
        y_pos <= wr_data[YPOS_W-1:0];
        state <= IDLE;
      end else begin
        case (state)
          IDLE: if (run_c) state <= FALL;
          FALL: begin
            if (!run_c) begin
              state <= IDLE;
            end else if (frame_start) begin
              y_pos <= y_next_c[YPOS_W-1:0];
              if (hit_limit_c) begin
                bar_missed     <= 1'b1;
                state          <= EXPIRED;
                ctrl[CTRL_RUN] <= 1'b0;
              end
            end
          end
          EXPIRED: state <= EXPIRED;
          default: state <= IDLE;
        endcase
      end
    end
  end

  // Stage 0: scan position relative to the bar, signed so off-bar pixels reject.
  logic signed [CALC_W-1:0] xrel_c;
  logic signed [CALC_W-1:0] yrel_c;
  logic                     in_region_c;
  logic                     drawable_c;
  logic [AW-1:0]            rd_addr_c;
  logic [CD-1:0]            ram_dout;

  assign xrel_c      = CALC_W'(x) - CALC_W'(x0);
  assign yrel_c      = CALC_W'(y) - {y_pos[YPOS_W-1], y_pos};
  assign in_region_c = (xrel_c[CALC_W-1:BAR_W_BITS] == '0) &&
                       (yrel_c[CALC_W-1:BAR_H_BITS] == '0);
  assign drawable_c  = enable_c && (state != EXPIRED);
  assign rd_addr_c   = {yrel_c[BAR_H_BITS-1:0], xrel_c[BAR_W_BITS-1:0]};

  bar_ram #(
    .ADDR_WIDTH (AW),
    .DATA_WIDTH (CD)
  ) u_bar_ram (
    .clk     (clk),
    .rst_n   (rst_n),
    .we      (spr_we),
    .wr_addr (spr_addr),
    .din     (spr_din),
    .rd_addr (rd_addr_c),
    .dout    (ram_dout)
  );

  // Stages 1 and 2: qualifiers travel with the RAM read, then the colour is keyed.
  logic in_region_d;
  logic drawable_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_region_d <= 1'b0;
      drawable_d  <= 1'b0;
      bar_rgb     <= '0;
      bar_valid   <= 1'b0;
    end else begin
      in_region_d <= in_region_c;
      drawable_d  <= drawable_c;
      bar_rgb     <= ram_dout;
      bar_valid   <= in_region_d && drawable_d && (ram_dout != KEY_COLOR);
    end
  end

endmodule
